// File: rtl/ddr_reset_seq.sv
// Power-up sequencer for NUM_CH DDR channels: staggered reset release, CKE enable,
// then init_done after a fixed settle time. Restartable by software at any point.
module ddr_reset_seq #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned RST_LOW_CYC = 20,
  parameter int unsigned STAGGER_CYC = 4,
  parameter int unsigned CKE_DLY_CYC = 50,
  parameter int unsigned INIT_CYC    = 10,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] ddr_reset_n,
  output logic [NUM_CH-1:0] cke,
  output logic              init_done,
  output logic              busy,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRstAssert = 3'd1,
    StCkeWait   = 3'd2,
    StInitWait  = 3'd3,
    StDone      = 3'd4
  } state_e;

  localparam longint unsigned CntLimit = 64'd1 << CNT_W;
  localparam longint unsigned RstMax   =
      longint'(RST_LOW_CYC) + longint'(NUM_CH - 1) * longint'(STAGGER_CYC);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("ddr_reset_seq: NUM_CH must be 1..8");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("ddr_reset_seq: CNT_W must be 1..32");
  end
  if (RST_LOW_CYC < 1 || CKE_DLY_CYC < 1 || INIT_CYC < 1) begin : g_bad_dur
    $error("ddr_reset_seq: phase durations must be >= 1");
  end
  if (RstMax >= CntLimit || longint'(CKE_DLY_CYC) >= CntLimit ||
      longint'(INIT_CYC) >= CntLimit) begin : g_bad_width
    $error("ddr_reset_seq: a phase duration does not fit in CNT_W bits");
  end

  // Thresholds are one less than the duration because outputs are registered.
  localparam logic [CNT_W-1:0] CkeThr  = CNT_W'(CKE_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] InitThr = CNT_W'(INIT_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  ddr_reset_n_q, ddr_reset_n_d;
  logic [NUM_CH-1:0]  cke_q, cke_d;
  logic               init_done_q, init_done_d;
  logic [NUM_CH-1:0]  rel_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rel
    localparam logic [CNT_W-1:0] RelThr = CNT_W'(RST_LOW_CYC + i * STAGGER_CYC - 1);
    assign rel_hit[i] = (cnt_q >= RelThr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      ddr_reset_n_q <= '0;
      cke_q         <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ddr_reset_n_q <= ddr_reset_n_d;
      cke_q         <= cke_d;
      init_done_q   <= init_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw_rst_req) begin
      state_d = StRstAssert;
    end else begin
      unique case (state_q)
        StIdle:      if (start) state_d = StRstAssert;
        StRstAssert: if (rel_hit[NUM_CH-1]) state_d = StCkeWait;
        StCkeWait:   if (cnt_q >= CkeThr) state_d = StInitWait;
        StInitWait:  if (cnt_q >= InitThr) state_d = StDone;
        StDone:      state_d = StDone;
        default:     state_d = StIdle;
      endcase
    end

    // Cleared on every entry (including a re-entry of RST_ASSERT); saturates, never wraps.
    cnt_d = cnt_q;
    if (sw_rst_req || state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    ddr_reset_n_d = ddr_reset_n_q;
    cke_d         = cke_q;
    init_done_d   = init_done_q;
    if (sw_rst_req) begin
      ddr_reset_n_d = '0;
      cke_d         = '0;
      init_done_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ddr_reset_n_d = '0;
          cke_d         = '0;
          init_done_d   = 1'b0;
        end
        StRstAssert: ddr_reset_n_d = ddr_reset_n_q | rel_hit;
        StCkeWait:   if (cnt_q >= CkeThr) cke_d = '1;
        StInitWait:  if (cnt_q >= InitThr) init_done_d = 1'b1;
        default:     ;
      endcase
    end
  end

  assign ddr_reset_n = ddr_reset_n_q;
  assign cke         = cke_q;
  assign init_done   = init_done_q;
  assign busy        = (state_q == StRstAssert) || (state_q == StCkeWait) ||
                       (state_q == StInitWait);
  assign state       = state_q;

endmodule

// File: tb/tb_ddr_reset_seq.sv
// Directed bench for ddr_reset_seq: default 2-channel instance plus a 4-channel,
// zero-stagger instance sharing the same stimulus.
module tb_ddr_reset_seq;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [1:0] a_rn, a_cke;
  logic       a_init, a_busy;
  logic [2:0] a_state;
  logic [3:0] b_rn, b_cke;
  logic       b_init, b_busy;
  logic [2:0] b_state;

  int n_checks = 0;
  int n_fail = 0;

  // Labels: "label n" is the value seen after the n-th edge counted from the edge that
  // sampled the request (labelled T), i.e. label n == time T+n in the requirements.
  int t_rn0, t_rn1, t_cke, t_init, t_busy_first, t_busy_last;
  int t_b_any, t_b_cke, t_b_init;
  logic [3:0] b_rn_at_any;
  logic rn_fell;
  logic [1:0] snap_rn, snap_cke;
  logic [2:0] snap_state;
  logic snap_init;

  always #5 clock = ~clock;

  ddr_reset_seq dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .sw_rst_req(sw_rst_req),
    .ddr_reset_n(a_rn), .cke(a_cke), .init_done(a_init), .busy(a_busy), .state(a_state)
  );

  ddr_reset_seq #(.NUM_CH(4), .STAGGER_CYC(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .sw_rst_req(sw_rst_req),
    .ddr_reset_n(b_rn), .cke(b_cke), .init_done(b_init), .busy(b_busy), .state(b_state)
  );

  task automatic clear_trackers();
    t_rn0 = -1; t_rn1 = -1; t_cke = -1; t_init = -1;
    t_busy_first = -1; t_busy_last = -1;
    t_b_any = -1; t_b_cke = -1; t_b_init = -1; b_rn_at_any = '0;
    rn_fell = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock); #2;
    reset_n = 1'b0;
    #10;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // Drives start at labels st1/st2/st3 and sw_rst_req at sw_t, recording first-event labels.
  task automatic run_trace(input int ncyc, input int st1, input int st2, input int st3,
                           input int sw_t);
    clear_trackers();
    for (int t = 0; t < ncyc; t++) begin
      start      = (t == st1) || (t == st2) || (t == st3);
      sw_rst_req = (t == sw_t);
      if (t == sw_t) clear_trackers();
      @(posedge clock); #1;
      start      = 1'b0;
      sw_rst_req = 1'b0;
      if (t == sw_t) begin
        snap_rn = a_rn; snap_cke = a_cke; snap_state = a_state; snap_init = a_init;
      end
      if (t_rn0 < 0 && a_rn[0]) t_rn0 = t + 1;
      if (t_rn1 < 0 && a_rn[1]) t_rn1 = t + 1;
      if (t_rn0 >= 0 && !a_rn[0]) rn_fell = 1'b1;
      if (t_cke < 0 && a_cke == 2'b11) t_cke = t + 1;
      if (t_init < 0 && a_init) t_init = t + 1;
      if (a_busy) begin
        if (t_busy_first < 0) t_busy_first = t + 1;
        t_busy_last = t + 1;
      end
      if (t_b_any < 0 && b_rn != 4'h0) begin
        t_b_any = t + 1;
        b_rn_at_any = b_rn;
      end
      if (t_b_cke < 0 && b_cke == 4'hf) t_b_cke = t + 1;
      if (t_b_init < 0 && b_init) t_b_init = t + 1;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #3;
    n_checks++;
    if ({a_rn, a_cke, a_init, a_busy, a_state} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0", {a_rn, a_cke, a_init, a_busy, a_state});
    end
    #20 reset_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    n_checks++;
    if (a_state !== 3'd0 || a_rn !== 2'b00 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_stays_idle: got state %0d rn %b expected 0 00", a_state, a_rn);
    end
  endtask

  task automatic test_single_start();
    apply_reset();
    run_trace(100, 0, -1, -1, -1);
    n_checks++; if (t_rn0 !== 21) begin n_fail++; $display("FAIL single_rn0: got %0d expected 21", t_rn0); end
    n_checks++; if (t_rn1 !== 25) begin n_fail++; $display("FAIL single_rn1: got %0d expected 25", t_rn1); end
    n_checks++; if (rn_fell !== 1'b0) begin n_fail++; $display("FAIL single_rn_hold: got %b expected 0", rn_fell); end
    n_checks++; if (t_cke !== 75) begin n_fail++; $display("FAIL single_cke: got %0d expected 75", t_cke); end
    n_checks++; if (t_init !== 85) begin n_fail++; $display("FAIL single_init: got %0d expected 85", t_init); end
    n_checks++; if (t_busy_first !== 1) begin n_fail++; $display("FAIL single_busy_first: got %0d expected 1", t_busy_first); end
    n_checks++; if (t_busy_last !== 84) begin n_fail++; $display("FAIL single_busy_last: got %0d expected 84", t_busy_last); end
    n_checks++; if (a_state !== 3'd4) begin n_fail++; $display("FAIL single_done_state: got %0d expected 4", a_state); end
    n_checks++; if (t_b_any !== 21) begin n_fail++; $display("FAIL ch4_release: got %0d expected 21", t_b_any); end
    n_checks++; if (b_rn_at_any !== 4'hf) begin n_fail++; $display("FAIL ch4_together: got %h expected f", b_rn_at_any); end
    n_checks++; if (t_b_cke !== 71) begin n_fail++; $display("FAIL ch4_cke: got %0d expected 71", t_b_cke); end
    n_checks++; if (t_b_init !== 81) begin n_fail++; $display("FAIL ch4_init: got %0d expected 81", t_b_init); end
  endtask

  task automatic test_sw_rst_mid();
    apply_reset();
    run_trace(160, 0, -1, -1, 60);
    n_checks++; if (snap_rn !== 2'b00 || snap_cke !== 2'b00) begin n_fail++; $display("FAIL swmid_outputs: got rn %b cke %b expected 00 00", snap_rn, snap_cke); end
    n_checks++; if (snap_state !== 3'd1) begin n_fail++; $display("FAIL swmid_state: got %0d expected 1", snap_state); end
    n_checks++; if (t_rn0 !== 81) begin n_fail++; $display("FAIL swmid_rn0: got %0d expected 81", t_rn0); end
    n_checks++; if (t_init !== 145) begin n_fail++; $display("FAIL swmid_init: got %0d expected 145", t_init); end
  endtask

  task automatic test_done_behaviour();
    apply_reset();
    run_trace(100, 0, -1, -1, -1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (a_state !== 3'd4 || a_init !== 1'b1 || a_cke !== 2'b11 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL done_start_ignored: got state %0d init %b cke %b busy %b expected 4 1 11 0", a_state, a_init, a_cke, a_busy);
    end
    run_trace(100, -1, -1, -1, 0);
    n_checks++; if (snap_init !== 1'b0 || snap_state !== 3'd1) begin n_fail++; $display("FAIL done_sw_drop: got init %b state %0d expected 0 1", snap_init, snap_state); end
    n_checks++; if (t_rn1 !== 25) begin n_fail++; $display("FAIL done_sw_rn1: got %0d expected 25", t_rn1); end
    n_checks++; if (t_init !== 85) begin n_fail++; $display("FAIL done_sw_init: got %0d expected 85", t_init); end
  endtask

  task automatic test_back_to_back_start();
    apply_reset();
    run_trace(100, 0, 5, 30, -1);
    n_checks++; if (t_rn0 !== 21) begin n_fail++; $display("FAIL b2b_rn0: got %0d expected 21", t_rn0); end
    n_checks++; if (t_rn1 !== 25) begin n_fail++; $display("FAIL b2b_rn1: got %0d expected 25", t_rn1); end
    n_checks++; if (t_cke !== 75) begin n_fail++; $display("FAIL b2b_cke: got %0d expected 75", t_cke); end
    n_checks++; if (t_init !== 85) begin n_fail++; $display("FAIL b2b_init: got %0d expected 85", t_init); end
  endtask

  task automatic test_async_reset_mid();
    logic active;
    apply_reset();
    run_trace(40, 0, -1, -1, -1);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_rn, a_cke, a_init, a_busy, a_state} !== 9'd0) begin
      n_fail++; $display("FAIL async_rst_a: got %b expected 0", {a_rn, a_cke, a_init, a_busy, a_state});
    end
    n_checks++;
    if ({b_rn, b_cke, b_init, b_busy, b_state} !== 13'd0) begin
      n_fail++; $display("FAIL async_rst_b: got %b expected 0", {b_rn, b_cke, b_init, b_busy, b_state});
    end
    #3 reset_n = 1'b1;
    active = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (a_state != 3'd0 || a_rn != 2'b00 || a_busy) active = 1'b1;
    end
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL async_rst_no_activity: got %b expected 0", active); end
  endtask

  initial begin
    test_reset();
    test_single_start();
    test_sw_rst_mid();
    test_done_behaviour();
    test_back_to_back_start();
    test_async_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
